// File: rtl/trap_seq_pkg.sv
// ============================================================================
// Module   : trap_seq_pkg
// Brief    : Shared types and constants for the SYSTEM-instruction sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package trap_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CSR_OP_NONE  = 3'b000,
    CSR_OP_ECALL = 3'b010,
    CSR_OP_MRET  = 3'b011,
    CSR_OP_RW    = 3'b100,
    CSR_OP_RS    = 3'b110
  } csr_op_e;

  typedef enum logic [1:0] {
    WSEL_ZERO = 2'd0,
    WSEL_RS1  = 2'd1,
    WSEL_IMM  = 2'd2
  } wsel_e;

  localparam logic [6:0]  C_OPC_SYSTEM  = 7'b1110011;
  localparam logic [2:0]  C_F3_PRIV     = 3'b000;
  localparam logic [2:0]  C_F3_CSRRW    = 3'b001;
  localparam logic [2:0]  C_F3_CSRRS    = 3'b010;
  localparam logic [2:0]  C_F3_CSRRWI   = 3'b101;
  localparam logic [2:0]  C_F3_CSRRSI   = 3'b110;

  localparam logic [11:0] C_CSR_MSTATUS = 12'h300;
  localparam logic [11:0] C_CSR_MTVEC   = 12'h305;
  localparam logic [11:0] C_CSR_MEPC    = 12'h341;
  localparam logic [11:0] C_CSR_MCAUSE  = 12'h342;

  localparam logic [11:0] C_F12_ECALL   = 12'h000;
  localparam logic [11:0] C_F12_MRET    = 12'h302;

endpackage

`default_nettype wire

// File: rtl/trap_seq_if.sv
// ============================================================================
// Module   : trap_seq_if
// Brief    : Decode, CSR-file and writeback handshakes of the trap sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface trap_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_val;

  logic        csr_req_valid;
  logic        csr_req_ready;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_pc;
  logic        csr_resp_valid;
  logic [31:0] csr_rdata;

  logic        out_valid;
  logic        out_ready;
  logic [4:0]  rd_idx;
  logic        rd_wen;
  logic [31:0] rd_wdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        illegal;

  modport slave (
    input  in_valid, inst, pc, rs1_val, csr_req_ready, csr_resp_valid,
           csr_rdata, out_ready,
    output in_ready, csr_req_valid, csr_op, csr_addr, csr_wdata, csr_pc,
           out_valid, rd_idx, rd_wen, rd_wdata, redir_valid, redir_pc, illegal
  );

  modport master (
    output in_valid, inst, pc, rs1_val, csr_req_ready, csr_resp_valid,
           csr_rdata, out_ready,
    input  in_ready, csr_req_valid, csr_op, csr_addr, csr_wdata, csr_pc,
           out_valid, rd_idx, rd_wen, rd_wdata, redir_valid, redir_pc, illegal
  );

endinterface

`default_nettype wire

// File: rtl/trap_seq_dec.sv
// ============================================================================
// Module   : trap_seq_dec
// Brief    : Combinational SYSTEM-opcode decoder. TRAP_SEQ_CSRI_EN adds
//            csrrwi/csrrsi decoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module trap_seq_dec
  import trap_seq_pkg::*;
(
  input  logic [31:0] i_inst,
  output csr_op_e     o_op,
  output logic [11:0] o_addr,
  output wsel_e       o_wsel,
  output logic [4:0]  o_rd,
  output logic        o_illegal
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1;
  logic [11:0] w_f12;

  assign w_opc = i_inst[6:0];
  assign w_f3  = i_inst[14:12];
  assign w_rs1 = i_inst[19:15];
  assign w_f12 = i_inst[31:20];
  assign o_rd  = i_inst[11:7];

  always_comb begin
    o_op      = CSR_OP_NONE;
    o_addr    = w_f12;
    o_wsel    = WSEL_ZERO;
    o_illegal = 1'b1;
    if (w_opc == C_OPC_SYSTEM) begin
      case (w_f3)
        C_F3_PRIV: begin
          // ecall reads the trap vector, mret reads the saved return pc
          if (w_f12 == C_F12_ECALL) begin
            o_op      = CSR_OP_ECALL;
            o_addr    = C_CSR_MTVEC;
            o_illegal = 1'b0;
          end else if (w_f12 == C_F12_MRET) begin
            o_op      = CSR_OP_MRET;
            o_addr    = C_CSR_MEPC;
            o_illegal = 1'b0;
          end
        end
        C_F3_CSRRW: begin
          o_op      = CSR_OP_RW;
          o_wsel    = WSEL_RS1;
          o_illegal = 1'b0;
        end
        C_F3_CSRRS: begin
          o_op      = CSR_OP_RS;
          o_wsel    = (w_rs1 == 5'd0) ? WSEL_ZERO : WSEL_RS1;
          o_illegal = 1'b0;
        end
`ifdef TRAP_SEQ_CSRI_EN
        C_F3_CSRRWI: begin
          o_op      = CSR_OP_RW;
          o_wsel    = WSEL_IMM;
          o_illegal = 1'b0;
        end
        C_F3_CSRRSI: begin
          o_op      = CSR_OP_RS;
          o_wsel    = WSEL_IMM;
          o_illegal = 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_seq.sv
// ============================================================================
// Module   : trap_seq
// Brief    : Sequences SYSTEM instructions through CSR-file request/response
//            to writeback. Option macro: TRAP_SEQ_CSRI_EN (in trap_seq_dec).
// Revision : 1.0
// ============================================================================
`default_nettype none

module trap_seq
  import trap_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  trap_seq_if.slave  bus
);

  state_e      r_state;
  logic        r_in_ready;
  logic        r_csr_req_valid;
  csr_op_e     r_csr_op;
  logic [11:0] r_csr_addr;
  logic [31:0] r_csr_wdata;
  logic [31:0] r_csr_pc;
  logic [4:0]  r_rd_pend;
  logic        r_out_valid;
  logic [4:0]  r_rd_idx;
  logic        r_rd_wen;
  logic [31:0] r_rd_wdata;
  logic        r_redir_valid;
  logic [31:0] r_redir_pc;
  logic        r_illegal;

  csr_op_e     w_dec_op;
  logic [11:0] w_dec_addr;
  wsel_e       w_dec_wsel;
  logic [4:0]  w_dec_rd;
  logic        w_dec_illegal;
  logic [31:0] w_wdata;

  trap_seq_dec u_dec (
    .i_inst    (bus.inst),
    .o_op      (w_dec_op),
    .o_addr    (w_dec_addr),
    .o_wsel    (w_dec_wsel),
    .o_rd      (w_dec_rd),
    .o_illegal (w_dec_illegal)
  );

  always_comb begin
    case (w_dec_wsel)
      WSEL_RS1: w_wdata = bus.rs1_val;
      WSEL_IMM: w_wdata = {27'd0, bus.inst[19:15]};
      default:  w_wdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_in_ready      <= 1'b1;
      r_csr_req_valid <= 1'b0;
      r_csr_op        <= CSR_OP_NONE;
      r_csr_addr      <= 12'd0;
      r_csr_wdata     <= 32'd0;
      r_csr_pc        <= 32'd0;
      r_rd_pend       <= 5'd0;
      r_out_valid     <= 1'b0;
      r_rd_idx        <= 5'd0;
      r_rd_wen        <= 1'b0;
      r_rd_wdata      <= 32'd0;
      r_redir_valid   <= 1'b0;
      r_redir_pc      <= 32'd0;
      r_illegal       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            if (w_dec_illegal) begin
              // nothing to ask the CSR file; report the fault straight away
              r_state       <= S_DONE;
              r_out_valid   <= 1'b1;
              r_illegal     <= 1'b1;
              r_rd_wen      <= 1'b0;
              r_redir_valid <= 1'b0;
            end else begin
              r_state         <= S_REQ;
              r_csr_req_valid <= 1'b1;
              r_csr_op        <= w_dec_op;
              r_csr_addr      <= w_dec_addr;
              r_csr_wdata     <= w_wdata;
              r_csr_pc        <= bus.pc;
              r_rd_pend       <= w_dec_rd;
            end
          end
        end
        S_REQ: begin
          if (bus.csr_req_ready) begin
            r_csr_req_valid <= 1'b0;
            r_state         <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.csr_resp_valid) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_illegal   <= 1'b0;
            if (r_csr_op == CSR_OP_ECALL || r_csr_op == CSR_OP_MRET) begin
              r_redir_valid <= 1'b1;
              r_redir_pc    <= bus.csr_rdata;
              r_rd_wen      <= 1'b0;
            end else begin
              r_redir_valid <= 1'b0;
              r_rd_idx      <= r_rd_pend;
              r_rd_wdata    <= bus.csr_rdata;
              r_rd_wen      <= (r_rd_pend != 5'd0);
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.csr_req_valid = r_csr_req_valid;
  assign bus.csr_op        = r_csr_op;
  assign bus.csr_addr      = r_csr_addr;
  assign bus.csr_wdata     = r_csr_wdata;
  assign bus.csr_pc        = r_csr_pc;
  assign bus.out_valid     = r_out_valid;
  assign bus.rd_idx        = r_rd_idx;
  assign bus.rd_wen        = r_rd_wen;
  assign bus.rd_wdata      = r_rd_wdata;
  assign bus.redir_valid   = r_redir_valid;
  assign bus.redir_pc      = r_redir_pc;
  assign bus.illegal       = r_illegal;

endmodule

`default_nettype wire
